// File: rtl/sram_fifo_ctrl.sv
// FIFO controller that queues words in an external single-port SRAM with 1-cycle read latency.
// Optional almost_full flag is built in when SRAM_FIFO_CTRL_ALMOST_EN is defined.
module sram_fifo_ctrl #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int AF_LVL = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_valid,
  input  logic [DW-1:0] push_data,
  output logic          push_ready,
  input  logic          pop_req,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
`ifdef SRAM_FIFO_CTRL_ALMOST_EN
  output logic          almost_full,
`endif
  output logic [AW-1:0] sram_addr,
  output logic          sram_wr_en,
  output logic          sram_rd_en,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  // Handshakes: a push transfers when push_valid && push_ready in the same
  // cycle; a pop is granted when pop_req && !empty, and its word appears one
  // cycle later with pop_valid=1. A pop grant takes the SRAM port and stalls push.

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count_next;
  logic          rd_go, wr_go;

  assign empty      = (count == '0);
  assign full       = (count == DEPTH);
  assign rd_go      = pop_req && !empty;
  assign push_ready = !full && !rd_go;
  assign wr_go      = push_valid && push_ready;
  assign pop_data   = sram_dout;

  always_comb begin
    sram_wr_en = 1'b0;
    sram_rd_en = 1'b0;
    sram_addr  = rptr;
    sram_din   = push_data;
    count_next = count;
    if (rd_go) begin
      sram_rd_en = 1'b1;
      count_next = count - 1'b1;
    end else if (wr_go) begin
      sram_wr_en = 1'b1;
      sram_addr  = wptr;
      count_next = count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= rd_go;
      count     <= count_next;
      if (rd_go) rptr <= rptr + 1'b1;
      if (wr_go) wptr <= wptr + 1'b1;
    end
  end

`ifdef SRAM_FIFO_CTRL_ALMOST_EN
  // Registered from the next count so the flag lines up with count itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) almost_full <= 1'b0;
    else        almost_full <= (count_next >= (AW+1)'(AF_LVL));
  end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed self-checking bench for sram_fifo_ctrl with a behavioural 1-cycle SRAM.
// Covers almost_full too when SRAM_FIFO_CTRL_ALMOST_EN is defined.
module tb_sram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          push_valid = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          push_ready;
  logic          pop_req = 1'b0;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic          full, empty;
  logic [AW:0]   count;
`ifdef SRAM_FIFO_CTRL_ALMOST_EN
  logic          almost_full;
`endif
  logic [AW-1:0] sram_addr;
  logic          sram_wr_en, sram_rd_en;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout = '0;

  logic [DW-1:0] mem [16];

  int checks = 0;
  int errors = 0;

  // bench model of the controller state
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] mw = '0, mr = '0;
  int            mc = 0;

  sram_fifo_ctrl #(.DW(DW), .AW(AW), .AF_LVL(14)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_valid(pop_valid), .pop_data(pop_data),
    .full(full), .empty(empty), .count(count),
`ifdef SRAM_FIFO_CTRL_ALMOST_EN
    .almost_full(almost_full),
`endif
    .sram_addr(sram_addr), .sram_wr_en(sram_wr_en), .sram_rd_en(sram_rd_en),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // clock / SRAM model
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_wr_en) mem[sram_addr] <= sram_din;
    if (sram_rd_en) sram_dout <= mem[sram_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    check("count", count, mc);
    check("empty", empty, mc == 0);
    check("full", full, mc == 16);
  endtask

  task automatic pop_expect();
    if (exp_q.size() == 0) check("exp_q_nonempty", 0, 1);
    else check("pop_data", pop_data, exp_q.pop_front());
  endtask

  // drivers: enter and leave 1 time unit after a rising edge
  task automatic do_push(input logic [DW-1:0] d);
    logic acc;
    acc = (mc != 16);
    push_valid = 1'b1; push_data = d; pop_req = 1'b0;
    #1;
    check("push_ready", push_ready, acc);
    check("wr_en", sram_wr_en, acc);
    if (acc) begin
      check("wr_addr", sram_addr, mw);
      check("din", sram_din, d);
      exp_q.push_back(d);
      mw++; mc++;
    end
    @(posedge clk); #1;
    push_valid = 1'b0;
    check_flags();
  endtask

  task automatic do_pop();
    logic g;
    g = (mc != 0);
    pop_req = 1'b1; push_valid = 1'b0;
    #1;
    check("rd_en", sram_rd_en, g);
    if (g) check("rd_addr", sram_addr, mr);
    @(posedge clk); #1;
    pop_req = 1'b0;
    check("pop_valid", pop_valid, g);
    if (g) begin
      pop_expect();
      mr++; mc--;
    end
    check_flags();
  endtask

  initial begin
    // reset
    #2;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_push_ready", push_ready, 1);
    check("rst_pop_valid", pop_valid, 0);
`ifdef SRAM_FIFO_CTRL_ALMOST_EN
    check("rst_almost_full", almost_full, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single word through, address 0
    do_push(8'hA5);
    do_pop();

    // fill to 16, drop the 17th, then drain back-to-back
    for (int i = 0; i < 16; i++) do_push(DW'(i));
    check("full_push_ready", push_ready, 0);
    do_push(8'h77);
    pop_req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      check("burst_rd_en", sram_rd_en, 1);
      check("burst_rd_addr", sram_addr, mr);
      @(posedge clk); #1;
      if (i == 15) pop_req = 1'b0;
      check("burst_pop_valid", pop_valid, 1);
      check("burst_order", pop_data, i);
      pop_expect();
      mr++; mc--;
    end
    @(posedge clk); #1;
    check("burst_end_valid", pop_valid, 0);
    check_flags();

    // simultaneous push and pop at count 3: read wins
    do_push(8'h10); do_push(8'h11); do_push(8'h12);
    push_valid = 1'b1; push_data = 8'h13; pop_req = 1'b1;
    #1;
    check("coll_push_ready", push_ready, 0);
    check("coll_rd_en", sram_rd_en, 1);
    check("coll_wr_en", sram_wr_en, 0);
    check("coll_addr", sram_addr, mr);
    @(posedge clk); #1;
    pop_req = 1'b0;
    check("coll_pop_valid", pop_valid, 1);
    pop_expect();
    mr++; mc--;
    check("coll_count", count, 2);
    #1;
    check("retry_push_ready", push_ready, 1);
    check("retry_wr_en", sram_wr_en, 1);
    check("retry_addr", sram_addr, mw);
    exp_q.push_back(8'h13);
    mw++; mc++;
    @(posedge clk); #1;
    push_valid = 1'b0;
    check("retry_count", count, 3);
    repeat (3) do_pop();

    // pop while empty is ignored
    do_pop();
    check("empty_count", count, 0);

    // wrap-around: 20 interleaved push/pop pairs
    for (int i = 0; i < 20; i++) begin
      do_push(DW'($urandom_range(0, 255)));
      do_pop();
    end

    // reset right after a pop grant
    do_push(8'h5A); do_push(8'h5B);
    pop_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0; pop_req = 1'b0;
    #1;
    check("mid_rst_pop_valid", pop_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    mw = '0; mr = '0; mc = 0; exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_pop_valid", pop_valid, 0);
    check_flags();

`ifdef SRAM_FIFO_CTRL_ALMOST_EN
    for (int i = 0; i < 14; i++) begin
      do_push(DW'(8'hC0 + i));
      check("almost_full", almost_full, mc >= 14);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
